// File: rtl/redun_mont_sched.sv
// redun_mont_sched: job sequencer for one redun_mont repeated-squaring core.
// Accepts a job (start value, iteration count T). It holds the core in reset
// between jobs and releases it for a job. It launches the first square, counts
// the squarings, emits periodic checkpoints and captures the T-th result. It
// then re-asserts the core reset. A no-progress watchdog parks the block in an
// error state until it is aborted.
// Ports:
//   i_clk, i_rst                          clock, async active-high reset
//   i_start_val/o_start_rdy               job handshake (i_start_dat, i_iter)
//   i_abort                               cancel the current job
//   o_core_rst/o_core_sq/o_core_val       drive the core i_rst/i_sq/i_val
//   i_core_mul/i_core_val                 core result and per-squaring pulse
//   o_ckpt_val/o_ckpt_dat/o_ckpt_idx      one-cycle checkpoint report
//   o_done_val/i_done_rdy/o_done_dat      final result handshake
//   o_busy, o_err_timeout                 status, sticky watchdog error
module redun_mont_sched #(
   parameter int unsigned SQ_W           = 1088,
   parameter int unsigned ITER_W         = 40,
   parameter int unsigned CKPT_INTERVAL  = 0,
   parameter int unsigned SETTLE_CYCLES  = 2,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start_val,
   output logic              o_start_rdy,
   input  logic [SQ_W-1:0]   i_start_dat,
   input  logic [ITER_W-1:0] i_iter,
   input  logic              i_abort,
   output logic              o_core_rst,
   output logic [SQ_W-1:0]   o_core_sq,
   output logic              o_core_val,
   input  logic [SQ_W-1:0]   i_core_mul,
   input  logic              i_core_val,
   output logic              o_ckpt_val,
   output logic [SQ_W-1:0]   o_ckpt_dat,
   output logic [ITER_W-1:0] o_ckpt_idx,
   output logic              o_done_val,
   input  logic              i_done_rdy,
   output logic [SQ_W-1:0]   o_done_dat,
   output logic              o_busy,
   output logic              o_err_timeout
);

   localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [5:0] {
      IDLE   = 6'b000001,
      SETTLE = 6'b000010,
      LOAD   = 6'b000100,
      RUN    = 6'b001000,
      DONE   = 6'b010000,
      ERR    = 6'b100000
   } state_e;

   state_e              state_q, state_d;
   logic                core_rst_q, core_rst_d;
   logic [SQ_W-1:0]     core_sq_q, core_sq_d;
   logic                core_val_q, core_val_d;
   logic                ckpt_val_q, ckpt_val_d;
   logic [SQ_W-1:0]     ckpt_dat_q, ckpt_dat_d;
   logic [ITER_W-1:0]   ckpt_idx_q, ckpt_idx_d;
   logic                done_val_q, done_val_d;
   logic [SQ_W-1:0]     done_dat_q, done_dat_d;
   logic                err_q, err_d;
   logic [ITER_W-1:0]   target_q, target_d;
   logic [ITER_W-1:0]   iter_cnt_q, iter_cnt_d;
   logic [ITER_W-1:0]   ckpt_cnt_q, ckpt_cnt_d;
   logic [SET_W-1:0]    settle_cnt_q, settle_cnt_d;
   logic [WD_W-1:0]     wdog_q, wdog_d;

   logic [ITER_W-1:0]   iter_nxt;
   logic [WD_W-1:0]     wdog_inc;
   logic                wdog_exp;
   logic                wdog_active;

   // State and output registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= IDLE;
         core_rst_q   <= 1'b1;
         core_sq_q    <= '0;
         core_val_q   <= 1'b0;
         ckpt_val_q   <= 1'b0;
         ckpt_dat_q   <= '0;
         ckpt_idx_q   <= '0;
         done_val_q   <= 1'b0;
         done_dat_q   <= '0;
         err_q        <= 1'b0;
         target_q     <= '0;
         iter_cnt_q   <= '0;
         ckpt_cnt_q   <= '0;
         settle_cnt_q <= '0;
         wdog_q       <= '0;
      end else begin
         state_q      <= state_d;
         core_rst_q   <= core_rst_d;
         core_sq_q    <= core_sq_d;
         core_val_q   <= core_val_d;
         ckpt_val_q   <= ckpt_val_d;
         ckpt_dat_q   <= ckpt_dat_d;
         ckpt_idx_q   <= ckpt_idx_d;
         done_val_q   <= done_val_d;
         done_dat_q   <= done_dat_d;
         err_q        <= err_d;
         target_q     <= target_d;
         iter_cnt_q   <= iter_cnt_d;
         ckpt_cnt_q   <= ckpt_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         wdog_q       <= wdog_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d      = state_q;
      core_rst_d   = core_rst_q;
      core_sq_d    = core_sq_q;
      core_val_d   = 1'b0;
      ckpt_val_d   = 1'b0;
      ckpt_dat_d   = ckpt_dat_q;
      ckpt_idx_d   = ckpt_idx_q;
      done_val_d   = done_val_q;
      done_dat_d   = done_dat_q;
      err_d        = err_q;
      target_d     = target_q;
      iter_cnt_d   = iter_cnt_q;
      ckpt_cnt_d   = ckpt_cnt_q;
      settle_cnt_d = settle_cnt_q;
      wdog_d       = wdog_q;

      iter_nxt    = iter_cnt_q + ITER_W'(1);
      wdog_inc    = wdog_q + WD_W'(1);
      wdog_exp    = (wdog_inc == WD_W'(TIMEOUT_CYCLES));
      wdog_active = (state_q == SETTLE) || (state_q == LOAD) ||
                    ((state_q == RUN) && !i_core_val);

      case (state_q)
         IDLE: begin
            core_rst_d = 1'b1;
            if (i_start_val) begin
               core_sq_d  = i_start_dat;
               target_d   = i_iter;
               iter_cnt_d = '0;
               ckpt_cnt_d = ITER_W'(CKPT_INTERVAL);
               wdog_d     = '0;
               if (i_iter == '0) begin
                  // Zero squarings: the start value is the result, core stays parked
                  state_d    = DONE;
                  done_val_d = 1'b1;
                  done_dat_d = i_start_dat;
               end else begin
                  state_d      = SETTLE;
                  core_rst_d   = 1'b0;
                  settle_cnt_d = '0;
               end
            end
         end

         SETTLE: begin
            wdog_d = wdog_inc;
            if (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
               state_d    = LOAD;
               core_val_d = 1'b1;
               wdog_d     = '0;
            end else begin
               settle_cnt_d = settle_cnt_q + SET_W'(1);
            end
         end

         LOAD: begin
            state_d = RUN;
            wdog_d  = wdog_inc;
         end

         RUN: begin
            if (i_core_val) begin
               wdog_d     = '0;
               iter_cnt_d = iter_nxt;
               if (iter_nxt == target_q) begin
                  // Final squaring: park the core on the same edge as the capture
                  state_d    = DONE;
                  done_val_d = 1'b1;
                  done_dat_d = i_core_mul;
                  core_rst_d = 1'b1;
               end else if (CKPT_INTERVAL != 0) begin
                  if (ckpt_cnt_q == ITER_W'(1)) begin
                     ckpt_cnt_d = ITER_W'(CKPT_INTERVAL);
                     ckpt_val_d = 1'b1;
                     ckpt_dat_d = i_core_mul;
                     ckpt_idx_d = iter_nxt;
                  end else begin
                     ckpt_cnt_d = ckpt_cnt_q - ITER_W'(1);
                  end
               end
            end else begin
               wdog_d = wdog_inc;
            end
         end

         DONE: begin
            core_rst_d = 1'b1;
            if (i_done_rdy) begin
               done_val_d = 1'b0;
               state_d    = IDLE;
            end
         end

         ERR: begin
            core_rst_d = 1'b1;
            err_d      = 1'b1;
         end

         default: begin
            state_d    = IDLE;
            core_rst_d = 1'b1;
         end
      endcase

      // Watchdog expiry; a core result in the same cycle counts as progress
      if (wdog_active && wdog_exp) begin
         state_d    = ERR;
         err_d      = 1'b1;
         core_rst_d = 1'b1;
         core_val_d = 1'b0;
         ckpt_val_d = 1'b0;
      end

      // Abort wins over everything else, including a final core result
      if (i_abort && (state_q != IDLE)) begin
         state_d    = IDLE;
         core_rst_d = 1'b1;
         core_val_d = 1'b0;
         ckpt_val_d = 1'b0;
         done_val_d = 1'b0;
         err_d      = 1'b0;
      end
   end

   assign o_start_rdy   = (state_q == IDLE);
   assign o_busy        = (state_q != IDLE);
   assign o_core_rst    = core_rst_q;
   assign o_core_sq     = core_sq_q;
   assign o_core_val    = core_val_q;
   assign o_ckpt_val    = ckpt_val_q;
   assign o_ckpt_dat    = ckpt_dat_q;
   assign o_ckpt_idx    = ckpt_idx_q;
   assign o_done_val    = done_val_q;
   assign o_done_dat    = done_dat_q;
   assign o_err_timeout = err_q;

endmodule

// File: tb/tb_redun_mont_sched.sv
// Bench for redun_mont_sched: behavioural squaring core (mod 1000003, 20-cycle
// latency), scoreboard of expected checkpoints/results from a reference
// computed as start^(2^k) mod N, and a separate monitor popping on each output.
module tb_redun_mont_sched;

   localparam int unsigned SQ_W  = 64;
   localparam int unsigned ITER_W = 16;
   localparam int unsigned CKPT  = 4;
   localparam int unsigned TMO   = 64;
   localparam int unsigned LAT   = 20;
   localparam logic [63:0] MOD   = 64'd1000003;

   typedef struct packed {
      logic [15:0] idx;
      logic [63:0] dat;
   } ckpt_t;

   logic              clk;
   logic              i_rst;
   logic              i_start_val;
   logic              o_start_rdy;
   logic [SQ_W-1:0]   i_start_dat;
   logic [ITER_W-1:0] i_iter;
   logic              i_abort;
   logic              o_core_rst;
   logic [SQ_W-1:0]   o_core_sq;
   logic              o_core_val;
   logic [SQ_W-1:0]   i_core_mul;
   logic              i_core_val;
   logic              o_ckpt_val;
   logic [SQ_W-1:0]   o_ckpt_dat;
   logic [ITER_W-1:0] o_ckpt_idx;
   logic              o_done_val;
   logic              i_done_rdy;
   logic [SQ_W-1:0]   o_done_dat;
   logic              o_busy;
   logic              o_err_timeout;

   int checks = 0;
   int errors = 0;

   ckpt_t       exp_ckpt[$];
   logic [63:0] exp_done[$];

   // Core model controls (written by the main process only)
   logic mute;
   int   abort_at;
   logic abort_now;
   // Core model state (written by the core model only)
   int          core_val_pulses;
   logic        m_busy;
   int          m_cnt;
   int          m_vals;
   logic [63:0] m_opnd;

   logic done_prev;

   redun_mont_sched #(
      .SQ_W(SQ_W), .ITER_W(ITER_W), .CKPT_INTERVAL(CKPT),
      .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .i_clk(clk), .i_rst(i_rst),
      .i_start_val(i_start_val), .o_start_rdy(o_start_rdy),
      .i_start_dat(i_start_dat), .i_iter(i_iter), .i_abort(i_abort),
      .o_core_rst(o_core_rst), .o_core_sq(o_core_sq), .o_core_val(o_core_val),
      .i_core_mul(i_core_mul), .i_core_val(i_core_val),
      .o_ckpt_val(o_ckpt_val), .o_ckpt_dat(o_ckpt_dat), .o_ckpt_idx(o_ckpt_idx),
      .o_done_val(o_done_val), .i_done_rdy(i_done_rdy), .o_done_dat(o_done_dat),
      .o_busy(o_busy), .o_err_timeout(o_err_timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #600000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "bench aborted");
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference: k successive squarings mod N
   function automatic logic [63:0] sq_pow(input logic [63:0] s, input int unsigned k);
      logic [63:0] v;
      v = s;
      for (int unsigned i = 0; i < k; i++) v = (v * v) % MOD;
      return v;
   endfunction

   // Expected outputs of a job whose lim-th core result gets cancelled (lim > t: runs to completion)
   task automatic push_exp(input logic [63:0] st, input int unsigned t, input int unsigned lim);
      ckpt_t c;
      for (int unsigned k = CKPT; k < t && k < lim; k += CKPT) begin
         c.idx = 16'(k);
         c.dat = sq_pow(st, k);
         exp_ckpt.push_back(c);
      end
      if (lim > t) exp_done.push_back(sq_pow(st, t));
   endtask

   // Behavioural core: squares its operand every LAT cycles and relaunches itself
   initial begin
      i_core_val = 1'b0;
      i_core_mul = '0;
      i_abort = 1'b0;
      core_val_pulses = 0;
      m_busy = 1'b0;
      m_cnt = 0;
      m_vals = 0;
      m_opnd = '0;
      forever begin
         @(posedge clk);
         #1;
         i_core_val = 1'b0;
         i_abort = abort_now;
         if (o_core_val) core_val_pulses++;
         if (o_core_rst) begin
            m_busy = 1'b0;
            m_vals = 0;
         end else if (o_core_val) begin
            m_busy = 1'b1;
            m_cnt = LAT;
            m_opnd = o_core_sq;
         end else if (m_busy && !mute) begin
            m_cnt--;
            if (m_cnt == 0) begin
               m_opnd = (m_opnd * m_opnd) % MOD;
               i_core_mul = m_opnd;
               i_core_val = 1'b1;
               m_vals++;
               m_cnt = LAT;
               if (abort_at != 0 && m_vals == abort_at) i_abort = 1'b1;
            end
         end
      end
   end

   // Monitor: pop and compare whenever the DUT presents a checkpoint or a new result
   initial begin
      ckpt_t e;
      logic [63:0] d;
      done_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (o_ckpt_val) begin
            if (exp_ckpt.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL ckpt_spurious: got idx %0d dat %0d expected no checkpoint", o_ckpt_idx, o_ckpt_dat);
            end else begin
               e = exp_ckpt.pop_front();
               check("ckpt_idx", 64'(o_ckpt_idx), 64'(e.idx));
               check("ckpt_dat", o_ckpt_dat, e.dat);
            end
         end
         if (o_done_val && !done_prev) begin
            if (exp_done.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL done_spurious: got dat %0d expected no result", o_done_dat);
            end else begin
               d = exp_done.pop_front();
               check("done_dat", o_done_dat, d);
            end
         end
         done_prev = o_done_val;
      end
   end

   task automatic issue_job(input logic [63:0] st, input int unsigned t);
      int n;
      n = 0;
      while (!o_start_rdy && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("start_rdy", 64'(o_start_rdy), 64'd1);
      i_start_val = 1'b1;
      i_start_dat = st;
      i_iter = 16'(t);
      @(negedge clk);
      i_start_val = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!o_done_val && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", 64'(o_done_val), 64'd1);
   endtask

   task automatic finish_job(input int unsigned dly);
      wait_done();
      repeat (dly) @(negedge clk);
      i_done_rdy = 1'b1;
      @(negedge clk);
      i_done_rdy = 1'b0;
      check("xfer_drop", 64'(o_done_val), 64'd0);
      check("rdy_after", 64'(o_start_rdy), 64'd1);
   endtask

   task automatic wait_vals(input int n);
      int seen;
      int cyc;
      seen = 0;
      cyc = 0;
      while (seen < n && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (i_core_val) seen++;
      end
      check("vals_seen", 64'(seen), 64'(n));
   endtask

   initial begin
      int pv;
      int n;
      logic [63:0] st;
      logic [63:0] dat0;
      int unsigned t;

      i_rst = 1'b1;
      i_start_val = 1'b0;
      i_start_dat = '0;
      i_iter = '0;
      i_done_rdy = 1'b0;
      mute = 1'b0;
      abort_at = 0;
      abort_now = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_core_rst", 64'(o_core_rst), 64'd1);
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_done_val", 64'(o_done_val), 64'd0);
      check("rst_core_val", 64'(o_core_val), 64'd0);
      check("rst_err", 64'(o_err_timeout), 64'd0);
      i_rst = 1'b0;
      @(negedge clk);
      check("rst_start_rdy", 64'(o_start_rdy), 64'd1);

      // start=5, T=3: one launch, result 5^8 mod N
      pv = core_val_pulses;
      push_exp(64'd5, 3, 4);
      issue_job(64'd5, 3);
      check("settle_rst_low", 64'(o_core_rst), 64'd0);
      check("settle_no_val0", 64'(o_core_val), 64'd0);
      @(negedge clk);
      check("settle_no_val1", 64'(o_core_val), 64'd0);
      @(negedge clk);
      check("load_val", 64'(o_core_val), 64'd1);
      check("load_sq", o_core_sq, 64'd5);
      wait_vals(3);
      check("rst_before_last", 64'(o_core_rst), 64'd0);
      @(negedge clk);
      check("rst_after_last", 64'(o_core_rst), 64'd1);
      check("t3_done_val", 64'(o_done_val), 64'd1);
      check("t3_dat_const", o_done_dat, 64'd390625);
      finish_job(0);
      check("t3_launches", 64'(core_val_pulses - pv), 64'd1);

      // T=0: immediate result, core never released
      pv = core_val_pulses;
      push_exp(64'd7, 0, 1);
      issue_job(64'd7, 0);
      check("t0_done_next", 64'(o_done_val), 64'd1);
      check("t0_dat", o_done_dat, 64'd7);
      check("t0_core_rst", 64'(o_core_rst), 64'd1);
      finish_job(0);
      check("t0_core_rst_end", 64'(o_core_rst), 64'd1);
      check("t0_launches", 64'(core_val_pulses - pv), 64'd0);

      // Checkpoints every 4 squarings, none on the final one
      push_exp(64'd3, 12, 13);
      issue_job(64'd3, 12);
      finish_job(1);
      check("ckpt_drained", 64'(exp_ckpt.size()), 64'd0);

      // Result held while not accepted; start requests ignored meanwhile
      st = 64'($urandom_range(2, 1000002));
      push_exp(st, 2, 3);
      issue_job(st, 2);
      wait_done();
      dat0 = o_done_dat;
      i_start_val = 1'b1;
      i_start_dat = 64'd11;
      i_iter = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold_val", 64'(o_done_val), 64'd1);
         check("hold_dat", o_done_dat, dat0);
         check("hold_rdy", 64'(o_start_rdy), 64'd0);
      end
      i_start_val = 1'b0;
      i_done_rdy = 1'b1;
      @(negedge clk);
      i_done_rdy = 1'b0;
      check("hold_xfer", 64'(o_done_val), 64'd0);
      check("hold_idle", 64'(o_start_rdy), 64'd1);
      @(negedge clk);
      check("hold_no_job", 64'(o_busy), 64'd0);

      // Abort on the 50th core result of a T=100 job
      abort_at = 50;
      st = 64'($urandom_range(2, 1000002));
      push_exp(st, 100, 50);
      issue_job(st, 100);
      wait_vals(50);
      check("abort_aligned", 64'(i_abort), 64'd1);
      @(negedge clk);
      abort_at = 0;
      check("abort_core_rst", 64'(o_core_rst), 64'd1);
      check("abort_idle", 64'(o_busy), 64'd0);
      check("abort_no_done", 64'(o_done_val), 64'd0);
      check("abort_no_ckpt", 64'(o_ckpt_val), 64'd0);
      repeat (5) @(negedge clk);
      st = 64'($urandom_range(2, 1000002));
      push_exp(st, 5, 6);
      issue_job(st, 5);
      finish_job(2);

      // Watchdog: silent core
      mute = 1'b1;
      issue_job(64'd9, 5);
      n = 0;
      while (!o_core_val && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("wd_load_seen", 64'(o_core_val), 64'd1);
      repeat (TMO - 1) @(negedge clk);
      check("wd_not_yet", 64'(o_err_timeout), 64'd0);
      @(negedge clk);
      check("wd_err", 64'(o_err_timeout), 64'd1);
      check("wd_core_rst", 64'(o_core_rst), 64'd1);
      repeat (20) @(negedge clk);
      check("wd_sticky", 64'(o_err_timeout), 64'd1);
      check("wd_busy", 64'(o_busy), 64'd1);
      abort_now = 1'b1;
      n = 0;
      while (o_busy && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("wd_abort_idle", 64'(o_busy), 64'd0);
      check("wd_err_clr", 64'(o_err_timeout), 64'd0);
      abort_now = 1'b0;
      mute = 1'b0;
      repeat (2) @(negedge clk);

      // Async reset mid-run
      st = 64'($urandom_range(2, 1000002));
      push_exp(st, 10, 3);
      issue_job(st, 10);
      wait_vals(2);
      #3;
      i_rst = 1'b1;
      #1;
      check("arst_core_rst", 64'(o_core_rst), 64'd1);
      check("arst_busy", 64'(o_busy), 64'd0);
      check("arst_rdy", 64'(o_start_rdy), 64'd1);
      check("arst_core_sq", o_core_sq, 64'd0);
      check("arst_ckpt_dat", o_ckpt_dat, 64'd0);
      check("arst_done_dat", o_done_dat, 64'd0);
      @(negedge clk);
      i_rst = 1'b0;
      repeat (2) @(negedge clk);

      // Randomized jobs
      for (int j = 0; j < 8; j++) begin
         st = 64'($urandom_range(1, 1000002));
         t = $urandom_range(0, 14);
         push_exp(st, t, t + 1);
         issue_job(st, t);
         finish_job($urandom_range(0, 3));
      end

      repeat (3) @(negedge clk);
      check("sb_done_empty", 64'(exp_done.size()), 64'd0);
      check("sb_ckpt_empty", 64'(exp_ckpt.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/redun_mont_sched.md
Name: redun_mont_sched

Overview:
- Job sequencer for the repeated-squaring core `redun_mont`.
- Accepts a job (start value plus iteration count T), then:
  - holds the core in reset between jobs;
  - releases the core and launches the first square;
  - counts completed squarings and emits periodic checkpoints;
  - captures the T-th result, then stops the core by re-asserting its reset.
- Sits between the host/AXI job interface and a single `redun_mont` instance.
- Includes a no-progress watchdog.

Parameters:
- SQ_W, 1088, width of a redundant-form operand (NUM_WRDS*(WRD_BITS+1) for the attached core).
- ITER_W, 40, width of the iteration count and counters.
- CKPT_INTERVAL, 0, emit a checkpoint every CKPT_INTERVAL squarings; 0 disables checkpoints.
- SETTLE_CYCLES, 2, cycles between core reset release and the o_core_val pulse (minimum 2).
- TIMEOUT_CYCLES, 4096, maximum cycles allowed between core results before the error state.

Ports:
- i_clk  in  1  clock; single clock domain.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start_val  in  1  job request.
- o_start_rdy  out  1  job accepted when i_start_val && o_start_rdy.
- i_start_dat  in  SQ_W  start value, redundant form.
- i_iter  in  ITER_W  number of squarings T.
- i_abort  in  1  cancel current job.
- o_core_rst  out  1  drives the core i_rst.
- o_core_sq  out  SQ_W  drives the core i_sq.
- o_core_val  out  1  drives the core i_val.
- i_core_mul  in  SQ_W  core o_mul.
- i_core_val  in  1  core o_val, one pulse per completed squaring.
- o_ckpt_val  out  1  one-cycle checkpoint pulse.
- o_ckpt_dat  out  SQ_W  checkpoint value.
- o_ckpt_idx  out  ITER_W  iteration number of the checkpoint.
- o_done_val  out  1  result valid, held until accepted.
- i_done_rdy  in  1  result accept.
- o_done_dat  out  SQ_W  result after T squarings.
- o_busy  out  1  state != IDLE.
- o_err_timeout  out  1  sticky watchdog error.

Behaviour:
- Reset values:
  - state IDLE;
  - o_core_rst=1;
  - o_core_val, o_ckpt_val, o_done_val, o_err_timeout, o_busy = 0;
  - data and counter registers = 0.
  - o_start_rdy = (state==IDLE), so it reads 1 once reset deasserts.
- All outputs are registered except o_start_rdy and o_busy.
- States (one-hot): IDLE, SETTLE, LOAD, RUN, DONE, ERR.
- IDLE:
  - o_core_rst=1.
  - On accept, latch i_start_dat into o_core_sq and i_iter into the target.
  - Clear iter_cnt; load ckpt_cnt=CKPT_INTERVAL.
  - If i_iter==0: next state DONE with o_done_dat=i_start_dat, and the core is never released.
  - Otherwise: next state SETTLE.
- SETTLE:
  - o_core_rst=0; o_core_sq stable.
  - Stay SETTLE_CYCLES cycles, then go to LOAD.
- LOAD:
  - o_core_val=1 for exactly one cycle.
  - Clear the watchdog; next state RUN.
- RUN, on each i_core_val:
  - iter_cnt += 1; clear the watchdog.
  - If new iter_cnt == target: capture i_core_mul into o_done_dat, set o_core_rst=1 on the same clock edge, go to DONE.
  - Else, if CKPT_INTERVAL != 0, decrement ckpt_cnt. When it reaches 0, reload it and pulse o_ckpt_val with o_ckpt_dat=i_core_mul and o_ckpt_idx=iter_cnt. Latency is one cycle after i_core_val.
  - The final iteration never produces a checkpoint, even when it is a multiple of CKPT_INTERVAL.
  - The core re-launches itself on each o_val, so the scheduler issues no further o_core_val.
- Watchdog (SETTLE/LOAD/RUN):
  - Counts cycles since LOAD or since the last i_core_val.
  - On reaching TIMEOUT_CYCLES: go to ERR, set o_err_timeout=1, set o_core_rst=1.
- DONE:
  - o_done_val=1 with o_done_dat stable until i_done_rdy.
  - On the transfer cycle, drop o_done_val and go to IDLE; o_start_rdy rises the following cycle.
- ERR:
  - Core held in reset; o_err_timeout stays 1.
  - Exited only by i_abort or i_rst, both going to IDLE and clearing o_err_timeout.
- i_abort in any non-IDLE state:
  - Next state IDLE; o_core_rst=1.
  - o_done_val and o_ckpt_val are forced 0 next cycle; no result is emitted.
- Simultaneous events:
  - i_abort beats a final i_core_val.
  - The watchdog expiring in the same cycle as i_core_val is not a timeout.
  - i_core_val outside RUN is ignored.
  - i_start_val while busy is ignored (not accepted).
- Async reset mid-job: immediately returns to the reset values, with o_core_rst=1 so the core halts.
- Counter width: iter_cnt and the target are ITER_W bits. The maximum T = 2^ITER_W-1 must complete without wrap.

Test Plan:
- Behavioural core model (squares mod N=1000003, 20-cycle latency), start=5, T=3, CKPT_INTERVAL=0:
  - exactly one o_core_val pulse;
  - o_done_dat=390625 (5^8 mod N);
  - o_core_rst high the cycle after the 3rd i_core_val;
  - o_start_rdy=1 after i_done_rdy.
- T=0, start=7 → o_done_val the next cycle with o_done_dat=7; o_core_rst never drops; zero o_core_val pulses.
- CKPT_INTERVAL=4, T=12, start=3 → checkpoints at idx 4 and 8 only (none at 12), each data matching the model; done at iteration 12.
- T=100, i_abort asserted on the cycle of the 50th i_core_val → no o_done_val, o_core_rst=1 next cycle, state IDLE, new job accepted and correct.
- Stub core never asserts i_core_val, TIMEOUT_CYCLES=64 → o_err_timeout rises 64 cycles after LOAD and stays set until i_abort.
- i_done_rdy held low for 10 cycles after done → o_done_val/o_done_dat stable throughout; i_start_val ignored; transfer on the first rdy cycle.
- Async reset pulse mid-RUN → all outputs return to the reset values and the core is held in reset.
